// File: rtl/shot_pkg.sv
// shot_pkg
//   Shared definitions for the shot pool: slot state encoding, the
//   fixed-point width derived from the number of fraction bits, and
//   pixel <-> fixed-point conversion helpers.
//   Fixed-point values are handled at CALC_W bits inside the helpers.
//   Callers sign-extend into CALC_W and truncate the result back to their own width.
package shot_pkg;

  localparam int PIX_W  = 11;  // screen coordinate width, integer pixels
  localparam int CALC_W = 32;  // working width inside the conversion helpers

  typedef enum logic {
    IDLE = 1'b0,
    FLY  = 1'b1
  } slot_state_t;

  // Position/velocity width: 11 integer bits, the fraction, plus sign and
  // one guard bit. The guard bit lets a shot step past the screen edge
  // without wrapping.
  function automatic int fix_width(input int frac);
    return PIX_W + frac + 2;
  endfunction

  // Integer pixel -> fixed point (pixel << frac), always non-negative.
  function automatic logic signed [CALC_W-1:0] to_fixed(input logic [PIX_W-1:0] pix,
                                                        input int frac);
    logic signed [CALC_W-1:0] wide;
    wide = $signed({{(CALC_W-PIX_W){1'b0}}, pix});
    return wide <<< frac;
  endfunction

  // Fixed point -> full signed pixel (arithmetic shift, floor toward -inf).
  function automatic logic signed [CALC_W-1:0] to_pixel_full(input logic signed [CALC_W-1:0] pos,
                                                             input int frac);
    return pos >>> frac;
  endfunction

  // Fixed point -> 11-bit pixel as driven on the output bus (truncated).
  function automatic logic [PIX_W-1:0] to_pixel(input logic signed [CALC_W-1:0] pos,
                                                input int frac);
    logic signed [CALC_W-1:0] full;
    full = pos >>> frac;
    return full[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/shot_slot.sv
// shot_slot
//   One projectile slot. It holds the IDLE/FLY state, the fixed-point
//   position and the velocity, and integrates the trajectory on each frame pulse.
//   Optional feature macro: SHOT_LIFETIME_EN adds a per-slot frame counter
//   that retires the shot after LIFETIME_FRAMES frames.
// Ports
//   clk        in   system clock
//   resetN     in   synchronous active-low reset
//   alloc      in   load launch state and enter FLY (only asserted while idle)
//   dir_left   in   launch direction, 1 = toward -X
//   launch_x/y in   launch position, integer pixels
//   sof        in   start-of-frame pulse, triggers one integration step
//   collision  in   hit indication, retires the slot when flying
//   en         out  slot is flying
//   idle       out  slot is free for allocation
//   pix_x/y    out  current position, integer pixels (11-bit truncated)
module shot_slot
  import shot_pkg::*;
#(
  parameter int FRAC_BITS = 6,
  parameter int X_SPEED   = 40,
  parameter int Y_SPEED   = 20,
  parameter int Y_ACCEL   = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479
`ifdef SHOT_LIFETIME_EN
  , parameter int LIFETIME_FRAMES = 90
`endif
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             alloc,
  input  logic             dir_left,
  input  logic [PIX_W-1:0] launch_x,
  input  logic [PIX_W-1:0] launch_y,
  input  logic             sof,
  input  logic             collision,
  output logic             en,
  output logic             idle,
  output logic [PIX_W-1:0] pix_x,
  output logic [PIX_W-1:0] pix_y
);

  localparam int FIX_W = fix_width(FRAC_BITS);
  typedef logic signed [FIX_W-1:0] fix_t;

  localparam fix_t VX_RIGHT = fix_t'(X_SPEED);
  localparam fix_t VX_LEFT  = fix_t'(-X_SPEED);
  localparam fix_t VY_INIT  = fix_t'(Y_SPEED);
  localparam fix_t AY       = fix_t'(Y_ACCEL);

  slot_state_t state_q, state_d;
  fix_t        pos_x_q, pos_x_d;
  fix_t        pos_y_q, pos_y_d;
  fix_t        vel_x_q, vel_x_d;
  fix_t        vel_y_q, vel_y_d;

  logic signed [CALC_W-1:0] pos_x_w, pos_y_w;
  logic signed [CALC_W-1:0] px_full, py_full;
  logic                     off_screen;
  logic                     expired;

  // Sign-extend into the helper width so the range check sees the true
  // signed pixel rather than the truncated output value.
  assign pos_x_w = {{(CALC_W-FIX_W){pos_x_q[FIX_W-1]}}, pos_x_q};
  assign pos_y_w = {{(CALC_W-FIX_W){pos_y_q[FIX_W-1]}}, pos_y_q};
  assign px_full = to_pixel_full(pos_x_w, FRAC_BITS);
  assign py_full = to_pixel_full(pos_y_w, FRAC_BITS);

  // The check runs on the registered position, so a shot that crosses
  // an edge is visible for one cycle and retires on the following edge.
  assign off_screen = (px_full < 0) || (px_full > X_MAX) ||
                      (py_full < 0) || (py_full > Y_MAX);

`ifdef SHOT_LIFETIME_EN
  localparam int AGE_W = $clog2(LIFETIME_FRAMES + 1);
  logic [AGE_W-1:0] age_q, age_d;

  assign expired = (age_q == AGE_W'(LIFETIME_FRAMES));

  always_comb begin
    age_d = age_q;
    if (state_q == IDLE) begin
      if (alloc) age_d = '0;
    end else if (!collision && !off_screen && !expired && sof) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) age_q <= '0;
    else         age_q <= age_d;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_x_d = vel_x_q;
    vel_y_d = vel_y_q;
    case (state_q)
      IDLE: begin
        if (alloc) begin
          state_d = FLY;
          pos_x_d = fix_t'(to_fixed(launch_x, FRAC_BITS));
          pos_y_d = fix_t'(to_fixed(launch_y, FRAC_BITS));
          vel_x_d = dir_left ? VX_LEFT : VX_RIGHT;
          vel_y_d = VY_INIT;
        end
      end
      FLY: begin
        // Retirement beats integration. A slot that is hit on a frame
        // pulse keeps the position it had when it was hit.
        if (collision || off_screen || expired) begin
          state_d = IDLE;
        end else if (sof) begin
          pos_x_d = pos_x_q + vel_x_q;
          pos_y_d = pos_y_q + vel_y_q;  // uses the pre-update Vy
          vel_y_d = vel_y_q + AY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      vel_x_q <= '0;
      vel_y_q <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_x_q <= vel_x_d;
      vel_y_q <= vel_y_d;
    end
  end

  assign en    = (state_q == FLY);
  assign idle  = (state_q == IDLE);
  assign pix_x = to_pixel(pos_x_w, FRAC_BITS);
  assign pix_y = to_pixel(pos_y_w, FRAC_BITS);

endmodule

// File: rtl/shot_pool_logic.sv
// shot_pool_logic
//   Multi-slot projectile engine. A rising edge on shootStart claims the
//   lowest-index free slot, which launches from Bumpy's position. Each
//   slot then integrates its own trajectory once per frame.
//   Optional feature macro: SHOT_LIFETIME_EN retires a shot after
//   LIFETIME_FRAMES frames.
// Ports
//   clk            in   system clock
//   resetN         in   synchronous active-low reset
//   startOfFrame   in   one-cycle frame pulse
//   shootStart     in   fire request (level, rising edge fires)
//   shootDirLeft   in   1 = fire toward -X
//   bumpyTopLeftX  in   launch X, integer pixels
//   bumpyTopLeftY  in   launch Y, integer pixels
//   shootCollision in   per-slot hit
//   shootEnable    out  per-slot in-flight flag
//   topLeftX       out  per-slot X, slot i at [i*11 +: 11]
//   topLeftY       out  per-slot Y, same packing
//   fireAccepted   out  pulse when a request got a slot
//   shotsFree      out  number of idle slots
module shot_pool_logic
  import shot_pkg::*;
#(
  parameter int NUM_SHOTS = 4,
  parameter int FRAC_BITS = 6,
  parameter int X_SPEED   = 40,
  parameter int Y_SPEED   = 20,
  parameter int Y_ACCEL   = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479
`ifdef SHOT_LIFETIME_EN
  , parameter int LIFETIME_FRAMES = 90
`endif
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           shootStart,
  input  logic                           shootDirLeft,
  input  logic [PIX_W-1:0]               bumpyTopLeftX,
  input  logic [PIX_W-1:0]               bumpyTopLeftY,
  input  logic [NUM_SHOTS-1:0]           shootCollision,
  output logic [NUM_SHOTS-1:0]           shootEnable,
  output logic [NUM_SHOTS*PIX_W-1:0]     topLeftX,
  output logic [NUM_SHOTS*PIX_W-1:0]     topLeftY,
  output logic                           fireAccepted,
  output logic [$clog2(NUM_SHOTS+1)-1:0] shotsFree
);

  localparam int FREE_W = $clog2(NUM_SHOTS + 1);

  logic                 shoot_prev_q, shoot_prev_d;
  logic                 fire_acc_q, fire_acc_d;
  logic                 fire_rise;
  logic [NUM_SHOTS-1:0] idle_vec;
  logic [NUM_SHOTS-1:0] alloc_vec;
  logic [FREE_W-1:0]    free_cnt;

  assign fire_rise = shootStart & ~shoot_prev_q;

  // The allocator looks at the registered slot states. A slot that
  // collides in this cycle still reads as FLY, so it cannot be reused
  // until the next cycle.
  always_comb begin
    alloc_vec    = '0;
    fire_acc_d   = 1'b0;
    shoot_prev_d = shootStart;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (fire_rise && idle_vec[i] && !fire_acc_d) begin
        alloc_vec[i] = 1'b1;
        fire_acc_d   = 1'b1;
      end
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      free_cnt = free_cnt + FREE_W'(idle_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      shoot_prev_q <= 1'b0;
      fire_acc_q   <= 1'b0;
    end else begin
      shoot_prev_q <= shoot_prev_d;
      fire_acc_q   <= fire_acc_d;
    end
  end

  assign fireAccepted = fire_acc_q;
  assign shotsFree    = free_cnt;

  for (genvar gi = 0; gi < NUM_SHOTS; gi++) begin : g_slot
    shot_slot #(
      .FRAC_BITS (FRAC_BITS),
      .X_SPEED   (X_SPEED),
      .Y_SPEED   (Y_SPEED),
      .Y_ACCEL   (Y_ACCEL),
      .X_MAX     (X_MAX),
      .Y_MAX     (Y_MAX)
`ifdef SHOT_LIFETIME_EN
      , .LIFETIME_FRAMES (LIFETIME_FRAMES)
`endif
    ) u_slot (
      .clk       (clk),
      .resetN    (resetN),
      .alloc     (alloc_vec[gi]),
      .dir_left  (shootDirLeft),
      .launch_x  (bumpyTopLeftX),
      .launch_y  (bumpyTopLeftY),
      .sof       (startOfFrame),
      .collision (shootCollision[gi]),
      .en        (shootEnable[gi]),
      .idle      (idle_vec[gi]),
      .pix_x     (topLeftX[gi*PIX_W +: PIX_W]),
      .pix_y     (topLeftY[gi*PIX_W +: PIX_W])
    );
  end

endmodule

// File: tb/tb_shot_pool_logic.sv
module tb_shot_pool_logic;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sof;
  logic        shoot_start;
  logic        dir_left;
  logic [10:0] bx, by;
  logic [3:0]  coll;

  logic [3:0]  en, g_en;
  logic [43:0] tlx, tly, g_tlx, g_tly;
  logic        fa, g_fa;
  logic [2:0]  free, g_free;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  shot_pool_logic dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .shootStart(shoot_start),
    .shootDirLeft(dir_left), .bumpyTopLeftX(bx), .bumpyTopLeftY(by),
    .shootCollision(coll), .shootEnable(en), .topLeftX(tlx), .topLeftY(tly),
    .fireAccepted(fa), .shotsFree(free)
  );

  // Second instance with gravity for the apex check; it shares the inputs.
  shot_pool_logic #(.Y_SPEED(-64), .Y_ACCEL(8)) dut_g (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .shootStart(shoot_start),
    .shootDirLeft(dir_left), .bumpyTopLeftX(bx), .bumpyTopLeftY(by),
    .shootCollision(coll), .shootEnable(g_en), .topLeftX(g_tlx), .topLeftY(g_tly),
    .fireAccepted(g_fa), .shotsFree(g_free)
  );

  function automatic logic [10:0] slot_px(input logic [43:0] v, input int i);
    return v[i*11 +: 11];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0; sof = 1'b0; shoot_start = 1'b0; coll = '0;
    tick();
    resetN = 1'b1;
  endtask

  task automatic fire();
    shoot_start = 1'b1;
    tick();
    shoot_start = 1'b0;
  endtask

  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; sof = 1'b0; shoot_start = 1'b0; dir_left = 1'b0;
    bx = 11'd100; by = 11'd200; coll = '0;
    tick(); tick();
    vec_cnt++; if (en !== 4'b0000) begin err_cnt++; $display("FAIL reset_en got %b want 0000", en); end
    vec_cnt++; if (tlx !== 44'd0) begin err_cnt++; $display("FAIL reset_x got %h want 0", tlx); end
    vec_cnt++; if (tly !== 44'd0) begin err_cnt++; $display("FAIL reset_y got %h want 0", tly); end
    vec_cnt++; if (fa !== 1'b0) begin err_cnt++; $display("FAIL reset_fa got %b want 0", fa); end
    vec_cnt++; if (free !== 3'd4) begin err_cnt++; $display("FAIL reset_free got %0d want 4", free); end
    resetN = 1'b1;
    tick();
    $display("test_reset done: vectors=%0d errors=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_single_shot();
    int exp_x[4] = '{100, 101, 101, 102};
    int exp_y[4] = '{200, 200, 200, 201};
    do_reset();
    bx = 11'd100; by = 11'd200; dir_left = 1'b0;
    fire();
    vec_cnt++; if (en !== 4'b0001) begin err_cnt++; $display("FAIL t1_en got %b want 0001", en); end
    vec_cnt++; if (fa !== 1'b1) begin err_cnt++; $display("FAIL t1_fa got %b want 1", fa); end
    vec_cnt++; if (slot_px(tlx, 0) !== 11'd100) begin err_cnt++; $display("FAIL t1_x0 got %0d want 100", slot_px(tlx, 0)); end
    vec_cnt++; if (slot_px(tly, 0) !== 11'd200) begin err_cnt++; $display("FAIL t1_y0 got %0d want 200", slot_px(tly, 0)); end
    tick();
    vec_cnt++; if (fa !== 1'b0) begin err_cnt++; $display("FAIL t1_fa_pulse got %b want 0", fa); end
    for (int f = 0; f < 4; f++) begin
      frame();
      vec_cnt++; if (slot_px(tlx, 0) !== 11'(exp_x[f])) begin err_cnt++; $display("FAIL t1_fx frame %0d got %0d want %0d", f+1, slot_px(tlx, 0), exp_x[f]); end
      vec_cnt++; if (slot_px(tly, 0) !== 11'(exp_y[f])) begin err_cnt++; $display("FAIL t1_fy frame %0d got %0d want %0d", f+1, slot_px(tly, 0), exp_y[f]); end
    end
    $display("test_single_shot done: vectors=%0d errors=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_fill_pool();
    logic [3:0] exp_en[3] = '{4'b0011, 4'b0111, 4'b1111};
    do_reset();
    bx = 11'd100; by = 11'd200; dir_left = 1'b0;
    // Held level fires exactly once.
    shoot_start = 1'b1;
    tick();
    vec_cnt++; if (fa !== 1'b1 || en !== 4'b0001) begin err_cnt++; $display("FAIL t2_first got fa=%b en=%b want fa=1 en=0001", fa, en); end
    tick(); tick();
    vec_cnt++; if (fa !== 1'b0 || en !== 4'b0001) begin err_cnt++; $display("FAIL t2_held got fa=%b en=%b want fa=0 en=0001", fa, en); end
    vec_cnt++; if (free !== 3'd3) begin err_cnt++; $display("FAIL t2_free1 got %0d want 3", free); end
    shoot_start = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      fire();
      vec_cnt++; if (fa !== 1'b1 || en !== exp_en[k]) begin err_cnt++; $display("FAIL t2_fire%0d got fa=%b en=%b want fa=1 en=%b", k+2, fa, en, exp_en[k]); end
      vec_cnt++; if (free !== 3'(2 - k)) begin err_cnt++; $display("FAIL t2_free%0d got %0d want %0d", k+2, free, 2 - k); end
      tick();
    end
    fire();
    vec_cnt++; if (fa !== 1'b0 || en !== 4'b1111) begin err_cnt++; $display("FAIL t2_fire5 got fa=%b en=%b want fa=0 en=1111", fa, en); end
    vec_cnt++; if (free !== 3'd0) begin err_cnt++; $display("FAIL t2_free5 got %0d want 0", free); end
    tick();
    $display("test_fill_pool done: vectors=%0d errors=%0d", vec_cnt, err_cnt);
  endtask

  // Continues from the full pool, with all slots at (100,200).
  task automatic test_collision();
    coll = 4'b0010; sof = 1'b1;
    tick();
    coll = '0; sof = 1'b0;
    vec_cnt++; if (en !== 4'b1101 || free !== 3'd1) begin err_cnt++; $display("FAIL t3_hit got en=%b free=%0d want en=1101 free=1", en, free); end
    frame();
    vec_cnt++; if (slot_px(tlx, 0) !== 11'd101) begin err_cnt++; $display("FAIL t3_x0 got %0d want 101", slot_px(tlx, 0)); end
    vec_cnt++; if (slot_px(tlx, 1) !== 11'd100 || slot_px(tly, 1) !== 11'd200) begin err_cnt++; $display("FAIL t3_frozen got (%0d,%0d) want (100,200)", slot_px(tlx, 1), slot_px(tly, 1)); end
    bx = 11'd300; by = 11'd50;
    fire();
    vec_cnt++; if (fa !== 1'b1 || en !== 4'b1111) begin err_cnt++; $display("FAIL t3_reuse got fa=%b en=%b want fa=1 en=1111", fa, en); end
    vec_cnt++; if (slot_px(tlx, 1) !== 11'd300 || slot_px(tly, 1) !== 11'd50) begin err_cnt++; $display("FAIL t3_reload got (%0d,%0d) want (300,50)", slot_px(tlx, 1), slot_px(tly, 1)); end
    tick();
    // A slot freed by a collision in the fire cycle is not allocatable yet.
    coll = 4'b0100; shoot_start = 1'b1;
    tick();
    coll = '0; shoot_start = 1'b0;
    vec_cnt++; if (fa !== 1'b0 || en !== 4'b1011) begin err_cnt++; $display("FAIL t3_fire_coll got fa=%b en=%b want fa=0 en=1011", fa, en); end
    tick();
    fire();
    vec_cnt++; if (fa !== 1'b1 || en !== 4'b1111 || slot_px(tlx, 2) !== 11'd300) begin err_cnt++; $display("FAIL t3_refire got fa=%b en=%b x2=%0d want fa=1 en=1111 x2=300", fa, en, slot_px(tlx, 2)); end
    tick();
    $display("test_collision done: vectors=%0d errors=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_offscreen();
    do_reset();
    bx = 11'd630; by = 11'd200; dir_left = 1'b0;
    fire();
    tick();
    for (int f = 0; f < 15; f++) frame();
    vec_cnt++; if (en[0] !== 1'b1 || slot_px(tlx, 0) !== 11'd639) begin err_cnt++; $display("FAIL t4_edge got en=%b x=%0d want en=1 x=639", en[0], slot_px(tlx, 0)); end
    frame();
    vec_cnt++; if (en[0] !== 1'b1 || slot_px(tlx, 0) !== 11'd640) begin err_cnt++; $display("FAIL t4_cross got en=%b x=%0d want en=1 x=640", en[0], slot_px(tlx, 0)); end
    tick();
    vec_cnt++; if (en !== 4'b0000 || free !== 3'd4) begin err_cnt++; $display("FAIL t4_retire_r got en=%b free=%0d want en=0000 free=4", en, free); end
    bx = 11'd2; dir_left = 1'b1;
    fire();
    tick();
    for (int f = 0; f < 3; f++) frame();
    vec_cnt++; if (en[0] !== 1'b1 || slot_px(tlx, 0) !== 11'd0) begin err_cnt++; $display("FAIL t4_left_edge got en=%b x=%0d want en=1 x=0", en[0], slot_px(tlx, 0)); end
    frame();
    vec_cnt++; if (en[0] !== 1'b1 || slot_px(tlx, 0) !== 11'd2047) begin err_cnt++; $display("FAIL t4_left_cross got en=%b x=%0d want en=1 x=2047", en[0], slot_px(tlx, 0)); end
    tick();
    vec_cnt++; if (en !== 4'b0000) begin err_cnt++; $display("FAIL t4_retire_l got en=%b want 0000", en); end
    $display("test_offscreen done: vectors=%0d errors=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_gravity();
    int exp_y[14] = '{199, 198, 197, 196, 196, 195, 195, 195, 195, 195, 195, 196, 196, 197};
    do_reset();
    bx = 11'd100; by = 11'd200; dir_left = 1'b0;
    // Fire on a frame pulse: the new shot skips that frame's integration.
    shoot_start = 1'b1; sof = 1'b1;
    tick();
    shoot_start = 1'b0; sof = 1'b0;
    vec_cnt++; if (g_en !== 4'b0001 || slot_px(g_tly, 0) !== 11'd200) begin err_cnt++; $display("FAIL t5_launch got en=%b y=%0d want en=0001 y=200", g_en, slot_px(g_tly, 0)); end
    tick();
    for (int f = 0; f < 14; f++) begin
      frame();
      vec_cnt++; if (slot_px(g_tly, 0) !== 11'(exp_y[f]) || g_en[0] !== 1'b1) begin err_cnt++; $display("FAIL t5_y frame %0d got y=%0d en=%b want y=%0d en=1", f+1, slot_px(g_tly, 0), g_en[0], exp_y[f]); end
    end
    $display("test_gravity done: vectors=%0d errors=%0d", vec_cnt, err_cnt);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bx = 11'd100; by = 11'd200; dir_left = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fire();
      tick();
    end
    frame();
    vec_cnt++; if (en !== 4'b0111 || free !== 3'd1) begin err_cnt++; $display("FAIL t6_pre got en=%b free=%0d want en=0111 free=1", en, free); end
    resetN = 1'b0; shoot_start = 1'b1;
    tick();
    vec_cnt++; if (en !== 4'b0000 || fa !== 1'b0) begin err_cnt++; $display("FAIL t6_en got en=%b fa=%b want en=0000 fa=0", en, fa); end
    vec_cnt++; if (tlx !== 44'd0 || tly !== 44'd0) begin err_cnt++; $display("FAIL t6_pos got x=%h y=%h want 0", tlx, tly); end
    vec_cnt++; if (free !== 3'd4) begin err_cnt++; $display("FAIL t6_free got %0d want 4", free); end
    shoot_start = 1'b0; resetN = 1'b1;
    tick();
    $display("test_reset_midflight done: vectors=%0d errors=%0d", vec_cnt, err_cnt);
  endtask

`ifdef SHOT_LIFETIME_EN
  task automatic test_lifetime();
    do_reset();
    bx = 11'd100; by = 11'd200; dir_left = 1'b0;
    fire();
    tick();
    for (int f = 0; f < 89; f++) frame();
    vec_cnt++; if (en[0] !== 1'b1) begin err_cnt++; $display("FAIL t6_life89 got en=%b want 1", en[0]); end
    frame();
    vec_cnt++; if (en[0] !== 1'b1) begin err_cnt++; $display("FAIL t6_life90 got en=%b want 1", en[0]); end
    tick();
    vec_cnt++; if (en[0] !== 1'b0) begin err_cnt++; $display("FAIL t6_expire got en=%b want 0", en[0]); end
    $display("test_lifetime done: vectors=%0d errors=%0d", vec_cnt, err_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_single_shot();
    test_fill_pool();
    test_collision();
    test_offscreen();
    test_gravity();
    test_reset_midflight();
`ifdef SHOT_LIFETIME_EN
    test_lifetime();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
